// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multicycle core: FETCH/DECODE/EXEC/MEM/WB stepping,
// datapath select decode, unconditioned write strobes and memory-stall trap.
// Optional retired-instruction counter enabled by defining MCFSM_PERF_CNT_EN.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [2:0] Funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic       NextPC,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NoWrite,
  output logic [1:0] FlagW,
`ifdef MCFSM_PERF_CNT_EN
  output logic       fault,
  output logic [31:0] retired
`else
  output logic       fault
`endif
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ALUWB,
    S_MEMADR,
    S_MEMRD,
    S_MEMWR,
    S_MEMWB,
    S_BRANCH,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fault;
  logic             r_boot;
  logic [2:0]       r_funct;
  logic             w_in_mem;
  logic             w_timeout;

  // r_boot marks the first cycle after reset: FETCH is entered but held
  // quiet (no request, no strobes) so reset never leaks a pulse.
  assign w_in_mem  = ((r_state == S_FETCH) && !r_boot) ||
                     (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout = w_in_mem && !mem_ready && (r_cnt == LP_LIMIT);
  assign fault     = r_fault;

  // State register, boot flag and latched Funct
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_boot  <= 1'b1;
      r_funct <= '0;
    end else begin
      r_state <= w_next;
      r_boot  <= 1'b0;
      if (r_state == S_DECODE) r_funct <= Funct;
    end
  end

  // Memory wait counter: cleared on any state change, counts stalled cycles
  always_ff @(posedge clk) begin
    if (reset || r_boot) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (w_in_mem && !mem_ready && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Sticky fault flag, set on entry to FAULT
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if ((w_next == S_FAULT) && (r_state != S_FAULT)) begin
      r_fault <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (!r_boot) begin
          if (mem_ready)      w_next = S_DECODE;
          else if (w_timeout) w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        unique case (Op)
          2'b00:   w_next = S_EXEC;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FAULT;
        endcase
      end
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_MEMADR: w_next = r_funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEMWR: begin
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEMWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FAULT;
    endcase
  end

  // Output decode from state; IRWrite/NextPC/MemW qualified by mem_ready
  always_comb begin
    mem_req    = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    NextPC     = 1'b0;
    PCS        = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    NoWrite    = 1'b0;
    FlagW      = 2'b00;
    unique case (r_state)
      S_FETCH: begin
        if (!r_boot) begin
          mem_req   = 1'b1;
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          NextPC    = mem_ready;
        end
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_EXEC: begin
        ALUSrcB = r_funct[2] ? 2'b01 : 2'b00;
        unique case (r_funct[1:0])
          2'b00: begin ALUControl = 2'b00; FlagW = 2'b11; end
          2'b01: begin ALUControl = 2'b01; FlagW = 2'b11; end
          2'b10: begin ALUControl = 2'b10; FlagW = 2'b10; end
          default: begin ALUControl = 2'b01; FlagW = 2'b11; end
        endcase
      end
      S_ALUWB: begin
        RegW    = 1'b1;
        NoWrite = (r_funct[1:0] == 2'b11);
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        MemW    = mem_ready;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCS       = 1'b1;
        RegW      = r_funct[2];
      end
      default: ;
    endcase
  end

`ifdef MCFSM_PERF_CNT_EN
  logic [31:0] r_retired;
  logic        w_retire;

  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_ALUWB) || (r_state == S_MEMWB) ||
                     (r_state == S_MEMWR) || (r_state == S_BRANCH));
  assign retired  = r_retired;

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset)         r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + 32'd1;
  end
`else
`endif

endmodule
